final_adder_arbiter: RTL
========================

# final_adder_arbiter

Shares one 128-bit carry-propagate final adder between two multiplier reduction lanes. Each lane presents a sum/carry operand pair. The arbiter grants lanes round-robin, registers the granted operands onto the shared adder's inputs, and captures the adder's result into a one-entry per-lane result buffer with valid/ready backpressure. It sits between the Dadda reduction trees and the product outputs; the adder itself is a separate combinational instance wired to the `add_*` ports.

## Interface
- `WIDTH`, 128: operand/sum width.
- `CNT_W`, 32: width of the completed-operation counter.

- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  lane has an operand pair.
- `req0_ready` / `req1_ready`  out  1  lane operand pair accepted this edge (combinational).
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH  operand pair per lane.
- `add_a`, `add_b`  out  WIDTH  registered operands driven to the shared adder.
- `add_s`  in  WIDTH  adder sum (combinational from `add_a`/`add_b`).
- `add_c`  in  1  adder carry-out of MSB.
- `rsp0_valid` / `rsp1_valid`  out  1  result buffer full.
- `rsp0_ready` / `rsp1_ready`  in  1  lane consumes result.
- `rsp0_sum` / `rsp1_sum`  out  WIDTH  buffered sum.
- `rsp0_carry` / `rsp1_carry`  out  1  buffered carry.
- `ops_done`  out  CNT_W  count of results delivered (rsp handshakes), wraps modulo 2^CNT_W.

## Operation
- Stage 1 (issue register): `op_vld`, `op_tag` (0/1), `add_a`, `add_b`.
- Stage 2 (result buffers): per lane `rspN_valid`, `rspN_sum`, `rspN_carry`.
- Stage-1 advance condition `adv = op_vld && (!rsp[op_tag]_valid || rsp[op_tag]_ready)`. On `adv`, `add_s`/`add_c` are written to the tagged buffer, and its valid is set.
- Stage 1 can load when `!op_vld || adv`.
- Arbitration applies only when stage 1 can load:
  - One valid lane: that lane is granted.
  - Both lanes valid: the lane not granted last is granted. The priority pointer `last` updates only on an accepted transfer.
- `reqN_ready = can_load && grantN`. The non-granted lane's ready is 0.
- Valid/ready rule: a lane may not drop `valid` or change operands until accepted. The arbiter's ready may drop without a transfer.
- Result buffer N clears on `rspN_valid && rspN_ready` unless refilled by `adv` the same edge; refill has priority, so valid stays 1 with the new data.
- `ops_done` increments by the number of rsp handshakes that edge (0, 1 or 2).
- Stalled stage 1 (its target buffer full, not draining): `add_a`/`add_b`/`op_tag` hold. The other lane cannot bypass it; both readies are 0.
- Reset (any time, including mid-operation): all in-flight operands and results are discarded, with no partial output.
- Reset values: `op_vld`=0, `add_a`=`add_b`=0, `op_tag`=0, `last`=1 (so lane 0 wins the first tie), all `rspN_valid`=0, all `rspN_sum`=0, all `rspN_carry`=0, `ops_done`=0. While `rstn`=0, `req0_ready`=`req1_ready`=0.
- The arbiter performs no arithmetic. Sum and carry are passed through verbatim from `add_s`/`add_c`.

## Timing
- Request accepted at edge E → `add_a`/`add_b` valid after E → result captured at E+1 → `rspN_valid`=1 after E+1. Minimum latency is 2 cycles.
- Aggregate throughput is 1 accept/cycle while result buffers drain; a single lane can sustain 1/cycle with `rsp_ready` held high.
- The adder's combinational path `add_a`/`add_b` → `add_s` must close within one cycle. There is no multicycle path.
- `reqN_ready` depends combinationally on `rspN_ready` (through `adv`). `rsp*` outputs are registered; there is no combinational path from `req*` to `rsp*`.

## Test plan
- Single lane 0: `a`=5, `b`=7, `rsp0_ready`=1 → `rsp0_sum`=12, `carry`=0, 2 cycles after accept; `ops_done`=1.
- Both lanes valid for 4 cycles, always ready → grants 0,1,0,1; each lane receives 2 correct results in order; `ops_done`=4.
- All-ones + all-ones on lane 1 → `rsp1_sum`=all ones except bit 0 = 0, `rsp1_carry`=1; 0 + 0 → sum 0, carry 0.
- Backpressure: lane 0 `rsp0_ready`=0 with 3 requests queued → first result held stable, second parked in stage 1, `req0_ready`=`req1_ready`=0. Releasing ready delivers results in order with no loss or duplication.
- Drain and refill the same edge: `rsp0_valid`=1, `rsp0_ready`=1 while stage 1 advances tag 0 → `rsp0_valid` stays 1 with the new sum; `ops_done` += 1.
- Assert `rstn`=0 mid-stream with both stages full → all valids 0 and `ops_done`=0 immediately. After release, the first tie is granted to lane 0.

Source files
------------

// File: rtl/final_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : final_adder_arbiter
// Description : Round-robin share of one carry-propagate final adder between
//               two reduction lanes, with a one-entry result buffer per lane.
// Revision    : 1.0
// ============================================================================
module final_adder_arbiter #(
   parameter int WIDTH = 128,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   input  logic [WIDTH-1:0] add_s,
   input  logic             add_c,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_sum,
   output logic             rsp0_carry,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_sum,
   output logic             rsp1_carry,
   output logic [CNT_W-1:0] ops_done
);

   logic r_op_vld;
   logic r_op_tag;
   logic r_last;
   logic w_tgt_free;
   logic w_adv;
   logic w_can_load;
   logic w_grant0;
   logic w_grant1;
   logic w_acc0;
   logic w_acc1;
   logic w_hs0;
   logic w_hs1;

   // r_last = 1 means lane 1 won the previous transfer, so lane 0 wins a tie.
   always_comb begin
      w_tgt_free = r_op_tag ? (!rsp1_valid || rsp1_ready) : (!rsp0_valid || rsp0_ready);
      w_adv      = r_op_vld && w_tgt_free;
      w_can_load = !r_op_vld || w_adv;
      w_grant0   = req0_valid && (!req1_valid || r_last);
      w_grant1   = req1_valid && (!req0_valid || !r_last);
      w_hs0      = rsp0_valid && rsp0_ready;
      w_hs1      = rsp1_valid && rsp1_ready;
   end

   assign w_acc0     = rstn && w_can_load && w_grant0;
   assign w_acc1     = rstn && w_can_load && w_grant1;
   assign req0_ready = w_acc0;
   assign req1_ready = w_acc1;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_op_vld   <= 1'b0;
         r_op_tag   <= 1'b0;
         r_last     <= 1'b1;
         add_a      <= '0;
         add_b      <= '0;
         rsp0_valid <= 1'b0;
         rsp0_sum   <= '0;
         rsp0_carry <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_sum   <= '0;
         rsp1_carry <= 1'b0;
         ops_done   <= '0;
      end else begin
         if (w_acc0 || w_acc1) begin
            r_op_vld <= 1'b1;
            r_op_tag <= w_acc1;
            r_last   <= w_acc1;
            add_a    <= w_acc1 ? req1_a : req0_a;
            add_b    <= w_acc1 ? req1_b : req0_b;
         end else if (w_adv) begin
            r_op_vld <= 1'b0;
         end

         // A refill on the same edge as a drain keeps the buffer valid.
         if (w_adv && !r_op_tag) begin
            rsp0_valid <= 1'b1;
            rsp0_sum   <= add_s;
            rsp0_carry <= add_c;
         end else if (w_hs0) begin
            rsp0_valid <= 1'b0;
         end

         if (w_adv && r_op_tag) begin
            rsp1_valid <= 1'b1;
            rsp1_sum   <= add_s;
            rsp1_carry <= add_c;
         end else if (w_hs1) begin
            rsp1_valid <= 1'b0;
         end

         ops_done <= ops_done + CNT_W'(w_hs0) + CNT_W'(w_hs1);
      end
   end

endmodule
`default_nettype wire
